// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: datapath width, iteration
// count, operation encodings, FSM state enum and a sign-magnitude helper.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Absolute value of a two's-complement operand when the operation is
    // signed; unsigned operands pass through untouched. 32'h80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                    input logic              is_signed);
        return (is_signed && value[DATA_W-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// -----------------------------------------------------------------------------
// mdu_div_core
// One combinational step of a radix-2 restoring divider on unsigned
// magnitudes. The caller holds the partial remainder and the dividend/quotient
// shift register and feeds the outputs back after every clock.
//
// Ports
//   rem      in   partial remainder (always < divisor once started)
//   quo      in   dividend bits still to shift in / quotient bits so far
//   divisor  in   divisor magnitude
//   rem_next out  partial remainder after this step
//   quo_next out  quotient register after this step
// -----------------------------------------------------------------------------
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] shifted;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (default first); a missing branch would otherwise infer a latch.
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        rem_next = shifted[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], 1'b0};
        if (shifted >= {1'b0, divisor}) begin
            // The true difference is below the divisor, so it fits in DATA_W
            // bits and a modulo-2^DATA_W subtraction yields it exactly.
            rem_next = shifted[DATA_W-1:0] - divisor;
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit with HI/LO result registers. Multiplies use
// a radix-2 shift-add over 32 cycles, divides a radix-2 restoring algorithm
// over 32 cycles; signed operations run on magnitudes and fix signs at commit.
// A start accepted at edge N commits HI/LO and pulses done after edge N+33.
//
// Configuration
//   MDU_DIV_EN  defined  : DIV/DIVU implemented (mdu_div_core instantiated).
//               undefined: no divider; op 1x goes straight to DONE and
//                          commits HI=LO=0 one cycle after acceptance.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   request an operation (sampled in IDLE only)
//   op         in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a  in   multiplicand / dividend
//   operand_b  in   multiplier / divisor
//   hi_we      in   MTHI strobe (IDLE only, start has priority)
//   lo_we      in   MTLO strobe (IDLE only, start has priority)
//   wdata      in   MTHI / MTLO data
//   busy       out  high in MUL, DIV and DONE
//   done       out  one-cycle pulse when HI/LO commit
//   hi_out     out  HI register
//   lo_out     out  LO register
// -----------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    state_e              state;
    op_e                 op_q;
    logic [CNT_W-1:0]    iter_cnt;
    // Shared iteration registers. Multiply: {acc_hi, acc_lo} is the product
    // shift register (acc_lo starts as the multiplier). Divide: acc_hi is the
    // partial remainder and acc_lo the dividend/quotient shift register.
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   opnd;      // multiplicand or divisor magnitude
    logic                neg_q;     // negate product / quotient at commit

    logic                is_signed_op;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   commit_hi;
    logic [DATA_W-1:0]   commit_lo;

    assign is_signed_op = ~op[0];

`ifdef MDU_DIV_EN
    logic                neg_r;     // remainder takes the dividend's sign
    logic                b_zero;    // divide by zero: override result
    logic [DATA_W-1:0]   a_raw;     // dividend as given, for divide by zero
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quo_next;

    mdu_div_core u_div_core (
        .rem      (acc_hi),
        .quo      (acc_lo),
        .divisor  (opnd),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );
`endif

    // Shift-add step: conditionally add the multiplicand into the upper half;
    // the carry is kept in mul_sum[DATA_W] and shifted down next clock.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    end

    // Result selection at commit, including sign fix-up.
    always_comb begin
        product = {acc_hi, acc_lo};
        if (neg_q) begin
            product = -product;
        end
        commit_hi = product[2*DATA_W-1:DATA_W];
        commit_lo = product[DATA_W-1:0];
        if (op_q[1]) begin
`ifdef MDU_DIV_EN
            if (b_zero) begin
                commit_hi = a_raw;
                commit_lo = '1;
            end else begin
                commit_hi = neg_r ? -acc_hi : acc_hi;
                commit_lo = neg_q ? -acc_lo : acc_lo;
            end
`else
            commit_hi = '0;
            commit_lo = '0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    // NOTE: all of these are plain flops (no memory arrays), so every one of
    // them, accumulators included, is cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_MULT;
            iter_cnt <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
`ifdef MDU_DIV_EN
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            a_raw    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Start wins over a simultaneous MTHI/MTLO.
                        op_q     <= op_e'(op);
                        iter_cnt <= '0;
                        acc_hi   <= '0;
                        busy     <= 1'b1;
                        if (!op[1]) begin
                            acc_lo <= magnitude(operand_b, is_signed_op);
                            opnd   <= magnitude(operand_a, is_signed_op);
                            neg_q  <= is_signed_op & (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
                            state  <= ST_MUL;
                        end else begin
`ifdef MDU_DIV_EN
                            acc_lo <= magnitude(operand_a, is_signed_op);
                            opnd   <= magnitude(operand_b, is_signed_op);
                            neg_q  <= is_signed_op & (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
                            neg_r  <= is_signed_op & operand_a[DATA_W-1];
                            b_zero <= (operand_b == '0);
                            a_raw  <= operand_a;
                            state  <= ST_DIV;
`else
                            state  <= ST_DONE;
`endif
                        end
                    end else begin
                        if (hi_we) begin
                            hi_out <= wdata;
                        end
                        if (lo_we) begin
                            lo_out <= wdata;
                        end
                    end
                end

                ST_MUL: begin
                    acc_hi   <= mul_sum[DATA_W:1];
                    acc_lo   <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (iter_cnt == CNT_W'(ITER_COUNT - 1)) begin
                        state <= ST_DONE;
                    end
                end

                ST_DIV: begin
`ifdef MDU_DIV_EN
                    acc_hi   <= rem_next;
                    acc_lo   <= quo_next;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (iter_cnt == CNT_W'(ITER_COUNT - 1)) begin
                        state <= ST_DONE;
                    end
`else
                    state <= ST_IDLE;
                    busy  <= 1'b0;
`endif
                end

                ST_DONE: begin
                    hi_out <= commit_hi;
                    lo_out <= commit_lo;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Scoreboard bench for mult_div_unit. Stimulus pushes the expected HI/LO and
// the cycle at which done must appear; a monitor on the falling edge pops and
// compares whenever done is high or a result is due. Expected values come
// from plain 64-bit arithmetic in ref_model (or spec constants for directed
// vectors). Honours MDU_DIV_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mdu_pkg::*;

`ifdef MDU_DIV_EN
    localparam int DLAT = 33;
`else
    localparam int DLAT = 1;
`endif
    localparam int MLAT = 33;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    // Architectural HI/LO as the stimulus side knows them.
    logic [31:0] cur_hi, cur_lo, pend_hi, pend_lo;
    logic        pend_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from the arithmetic definition of each operation.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        lat = MLAT;
        case (o)
            2'b00:   p = sa * sbv;
            2'b01:   p = {32'b0, a} * {32'b0, b};
            default: begin
                if (o[0]) begin
                    sa  = longint'({32'b0, a});
                    sbv = longint'({32'b0, b});
                end
                if (b == 32'd0) begin
                    q = -1;
                    r = sa;
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                end
                p   = {r[31:0], q[31:0]};
                lat = DLAT;
`ifndef MDU_DIV_EN
                p = '0;
`endif
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares done against the scoreboard head and checks results.
    logic exp_done;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            exp_done = (sb.size() > 0) && (sb[0].due == cyc);
            if (done || exp_done) begin
                check("done_timing", done, exp_done);
                if (exp_done) begin
                    mon_e = sb.pop_front();
                    check("hi_result", hi_out, mon_e.hi);
                    check("lo_result", lo_out, mon_e.lo);
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge with busy low.
    task automatic wait_idle();
        for (int i = 0; busy !== 1'b0; i++) begin
            if (i >= 200) begin
                check("wait_idle_timeout", busy, 0);
                break;
            end
            @(negedge clk);
        end
        if (pend_valid) begin
            cur_hi     = pend_hi;
            cur_lo     = pend_lo;
            pend_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        int n;
        wait_idle();
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        n = cyc;
        sb.push_back('{due: n + lat + 1, hi: ehi, lo: elo});
        pend_hi    = ehi;
        pend_lo    = elo;
        pend_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (lat > 1) check("busy_after_start", busy, 1);
    endtask

    task automatic issue_rand(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        int          lat;
        ref_model(o, a, b, ehi, elo, lat);
        issue(o, a, b, ehi, elo, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        op         = 2'b00;
        operand_a  = '0;
        operand_b  = '0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        wdata      = '0;
        cur_hi     = '0;
        cur_lo     = '0;
        pend_hi    = '0;
        pend_lo    = '0;
        pend_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi_out, 0);
        check("reset_lo", lo_out, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MLAT);
        issue(OP_MULT, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MLAT);
`ifdef MDU_DIV_EN
        issue(OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DLAT);
        issue(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DLAT);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DLAT);
`else
        issue(OP_DIV, -32'sd7, 32'd2, 32'h0, 32'h0, DLAT);
        issue(OP_DIVU, 32'd100, 32'd0, 32'h0, 32'h0, DLAT);
`endif
        wait_idle();
        check("hi_hold_after_done", hi_out, cur_hi);
        check("lo_hold_after_done", lo_out, cur_lo);

        // MTHI in IDLE, then both strobes together.
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", hi_out, 32'h1234);
        check("mthi_lo_untouched", lo_out, cur_lo);
        cur_hi = 32'h1234;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        wdata  = 32'hA5A5_0F0F;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_both_hi", hi_out, 32'hA5A5_0F0F);
        check("mt_both_lo", lo_out, 32'hA5A5_0F0F);
        cur_hi = 32'hA5A5_0F0F;
        cur_lo = 32'hA5A5_0F0F;

        // Start together with MTHI: the write is dropped.
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        issue_rand(OP_MULTU, 32'd6, 32'd9);
        check("start_beats_mthi", hi_out, cur_hi);

        // Reset partway through a MULT.
        issue_rand(OP_MULT, 32'h0001_2345, -32'sd77);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi_out, 0);
        check("abort_lo", lo_out, 0);
        sb.delete();
        pend_valid = 1'b0;
        cur_hi     = '0;
        cur_lo     = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // MULTU 3 x 4 after the abort, with an MTLO attempted while busy.
        issue(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, MLAT);
        lo_we = 1'b1;
        wdata = 32'd5;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_busy_ignored", lo_out, cur_lo);
        repeat (5) @(negedge clk);
        check("mtlo_busy_still", lo_out, cur_lo);
        wait_idle();
        check("multu_3x4_lo", lo_out, 32'd12);

        // Second start while busy is ignored; monitor sees one done only.
        issue_rand(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
        @(negedge clk);
        op        = OP_DIVU;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_second_start", busy, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("single_done_busy_low", busy, 0);

        // Randomized operations, occasionally interleaved with MTHI/MTLO.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            ro = 2'($urandom_range(0, 3));
            issue_rand(ro, rand_val(), rand_val());
            if ($urandom_range(0, 4) == 0) begin
                wait_idle();
                hi_we = 1'b1;
                lo_we = ($urandom_range(0, 1) == 1);
                wdata = $urandom;
                @(negedge clk);
                check("rand_mthi", hi_out, wdata);
                if (lo_we) cur_lo = wdata;
                cur_hi = wdata;
                check("rand_mtlo", lo_out, cur_lo);
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 operand_a  in  32  multiplicand or dividend; captured on the accepted start.
REQ-007 operand_b  in  32  multiplier or divisor; captured on the accepted start.
REQ-008 hi_we / lo_we  in  1 each  MTHI / MTLO write strobes.
REQ-009 wdata  in  32  data for MTHI / MTLO.
REQ-010 busy  out  1  operation in progress; the pipeline stalls on it.
REQ-011 done  out  1  one-cycle pulse when a result commits to HI/LO.
REQ-012 hi_out / lo_out  out  32 each  registered HI/LO; these feed the 32-bit 3:1 result mux inputs 1 and 2.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-014 start in IDLE SHALL go to MUL (op 0x) or DIV (op 1x) and latch both operands and op; start outside IDLE SHALL be ignored.
REQ-015 MUL and DIV SHALL each run exactly 32 iteration cycles (radix-2 shift-add / restoring), then enter DONE.
REQ-016 In DONE, HI/LO SHALL update, done SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-017 Latency: start accepted at edge N -> done high and new HI/LO visible after edge N+33.
REQ-018 busy SHALL be 1 in the MUL, DIV and DONE states, and 0 in IDLE.
REQ-019 MULT/MULTU: {HI,LO} SHALL equal the 64-bit signed or unsigned product.
REQ-020 Signed ops SHALL compute on magnitudes and then negate the result as needed.
REQ-021 DIV/DIVU: LO SHALL be the quotient and HI the remainder; the signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-022 Divide by zero SHALL give LO=32'hFFFFFFFF, HI=operand_a, with normal latency.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-024 hi_we / lo_we in IDLE SHALL write wdata to HI / LO at the next edge; asserting both writes both.
REQ-025 hi_we / lo_we while busy SHALL be ignored.
REQ-026 start and hi_we/lo_we together in IDLE: start SHALL win and the write SHALL be dropped.
REQ-027 HI/LO SHALL hold their values between completions and writes.

Reset
REQ-028 reset SHALL force IDLE, busy=0, done=0, hi_out=0, lo_out=0 and clear all internal accumulators.
REQ-029 reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave normally.

Configuration
REQ-030 Macro MDU_DIV_EN defined: DIV/DIVU SHALL be implemented as specified above.
REQ-031 Macro MDU_DIV_EN undefined: no divider logic; op 1x SHALL go IDLE->DONE (done after edge N+1) with HI=LO=0; multiply behaviour SHALL be unchanged.

Structure
REQ-032 Package mdu_pkg SHALL hold the op encodings, the FSM state enum, DATA_W and the iteration count constant (32).
REQ-033 The restoring-divide iteration SHALL be sub-module mdu_div_core, instantiated only under MDU_DIV_EN.

Verification
REQ-034 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 33 cycles HI=32'hFFFFFFFE, LO=32'h00000001, one done pulse.
REQ-035 MULT -3 x 7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-036 DIVU 100 / 0 -> LO=32'hFFFFFFFF, HI=100; DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
REQ-037 MTHI 32'h1234 in IDLE -> hi_out=32'h1234 the next cycle; MTLO 5 during busy -> lo_out unchanged until done.
REQ-038 reset at cycle 10 of a MULT -> busy=0, HI=LO=0, no done; a new MULTU 3 x 4 -> LO=12 after 33 cycles.
REQ-039 A second start while busy -> ignored; the first result is intact and exactly one done pulse occurs.
